// File: rtl/phase_error_counter.sv
// Phase error counter between a reference clock and a divided DCO feedback clock.
// Both clocks are synchronized into the fpga_clk_i domain and edge-detected; the
// first edge to arrive starts a signed count (positive when ref leads) that stops
// on the other clock's edge and is reported for one cycle with trigger_o.
//
// Ports:
//   fpga_clk_i     system clock, all state on its rising edge
//   reset_n_i      asynchronous active-low reset
//   enable_i       measurement enable (fpga_clk_i domain)
//   ref_clk_i      reference clock (asynchronous)
//   dco_clk_i      divided DCO feedback clock (asynchronous)
//   counter_val_o  signed phase error in fpga_clk_i cycles
//   trigger_o      one-cycle pulse while counter_val_o holds a finished measurement
//   cycle_slip_o   one-cycle pulse when the leading clock edges twice
//   state_o        FSM state, debug only
module phase_error_counter #(
   parameter int unsigned WIDTH = 20
) (
   input  logic             fpga_clk_i,
   input  logic             reset_n_i,
   input  logic             enable_i,
   input  logic             ref_clk_i,
   input  logic             dco_clk_i,
   output logic [WIDTH-1:0] counter_val_o,
   output logic             trigger_o,
   output logic             cycle_slip_o,
   output logic [2:0]       state_o
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] LEAD_REF = 3'd1;
   localparam logic [2:0] LEAD_DCO = 3'd2;
   localparam logic [2:0] REPORT   = 3'd3;
   localparam logic [2:0] CLEAR    = 3'd4;

   localparam logic [WIDTH-1:0] CNT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] CNT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       ref_sync;
   logic [1:0]       dco_sync;
   logic             ref_prev;
   logic             dco_prev;
   logic             ref_edge;
   logic             dco_edge;
   logic [1:0]       arm_cnt;
   logic             armed;

   logic [2:0]       state;
   logic [2:0]       state_next;
   logic [WIDTH-1:0] cnt_next;
   logic             trig_next;
   logic             slip_next;

   // Edges are masked until the synchronizers have been filled after reset, so a
   // level already high at reset release is not taken for a rising edge.
   assign armed = (arm_cnt == 2'd3);

   // Synchronizers and registered rising-edge detectors.
   always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ref_sync <= 2'b00;
         dco_sync <= 2'b00;
         ref_prev <= 1'b0;
         dco_prev <= 1'b0;
         ref_edge <= 1'b0;
         dco_edge <= 1'b0;
         arm_cnt  <= 2'd0;
      end else begin
         ref_sync <= {ref_sync[0], ref_clk_i};
         dco_sync <= {dco_sync[0], dco_clk_i};
         ref_prev <= ref_sync[1];
         dco_prev <= dco_sync[1];
         ref_edge <= armed & ref_sync[1] & ~ref_prev;
         dco_edge <= armed & dco_sync[1] & ~dco_prev;
         if (!armed) begin
            arm_cnt <= arm_cnt + 2'd1;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state         <= IDLE;
         counter_val_o <= '0;
         trigger_o     <= 1'b0;
         cycle_slip_o  <= 1'b0;
      end else begin
         state         <= state_next;
         counter_val_o <= cnt_next;
         trigger_o     <= trig_next;
         cycle_slip_o  <= slip_next;
      end
   end

   assign state_o = state;

   // Next-state and next-output logic.
   always_comb begin
      state_next = state;
      cnt_next   = counter_val_o;
      slip_next  = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (enable_i) begin
               if (ref_edge && dco_edge) begin
                  state_next = REPORT;
               end else if (ref_edge) begin
                  state_next = LEAD_REF;
                  cnt_next   = WIDTH'(1);
               end else if (dco_edge) begin
                  state_next = LEAD_DCO;
                  cnt_next   = '1;
               end
            end
         end
         LEAD_REF: begin
            if (!enable_i) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end else if (dco_edge) begin
               // Lagging edge closes the measurement; a coincident ref edge is dropped.
               state_next = REPORT;
            end else begin
               if (counter_val_o != CNT_MAX) begin
                  cnt_next = counter_val_o + WIDTH'(1);
               end
               slip_next = ref_edge;
            end
         end
         LEAD_DCO: begin
            if (!enable_i) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end else if (ref_edge) begin
               state_next = REPORT;
            end else begin
               if (counter_val_o != CNT_MIN) begin
                  cnt_next = counter_val_o - WIDTH'(1);
               end
               slip_next = dco_edge;
            end
         end
         REPORT: begin
            state_next = CLEAR;
            cnt_next   = '0;
         end
         CLEAR: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
      trig_next = (state_next == REPORT);
   end

endmodule

// File: tb/tb_phase_error_counter.sv
// Bench for phase_error_counter: two instances (WIDTH=20 and WIDTH=4) share the
// stimulus; expected outputs come from a timeline model of the measurement.
module tb_phase_error_counter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        ref_clk;
   logic        dco_clk;
   logic [19:0] cnt20;
   logic [3:0]  cnt4;
   logic        trig20, trig4;
   logic        slip20, slip4;
   logic [2:0]  st20, st4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   phase_error_counter #(.WIDTH(20)) u_dut20 (
      .fpga_clk_i   (clk),
      .reset_n_i    (rst_n),
      .enable_i     (enable),
      .ref_clk_i    (ref_clk),
      .dco_clk_i    (dco_clk),
      .counter_val_o(cnt20),
      .trigger_o    (trig20),
      .cycle_slip_o (slip20),
      .state_o      (st20)
   );

   phase_error_counter #(.WIDTH(4)) u_dut4 (
      .fpga_clk_i   (clk),
      .reset_n_i    (rst_n),
      .enable_i     (enable),
      .ref_clk_i    (ref_clk),
      .dco_clk_i    (dco_clk),
      .counter_val_o(cnt4),
      .trigger_o    (trig4),
      .cycle_slip_o (slip4),
      .state_o      (st4)
   );

   function automatic int clampw(input int v, input int w);
      int hi;
      int lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   task automatic chk_all(input string tag, input int ev, input bit et, input bit es);
      chk({tag, "/cnt20"},  32'($signed(cnt20)), 32'(clampw(ev, 20)));
      chk({tag, "/cnt4"},   32'($signed(cnt4)),  32'(clampw(ev, 4)));
      chk({tag, "/trig20"}, 32'(trig20), 32'(et));
      chk({tag, "/trig4"},  32'(trig4),  32'(et));
      chk({tag, "/slip20"}, 32'(slip20), 32'(es));
      chk({tag, "/slip4"},  32'(slip4),  32'(es));
   endtask

   // lead: +1 ref first, -1 dco first, 0 both together. The lagging clock rises n
   // cycles after the leading one. An internal edge trails the raw edge by 3
   // cycles and the FSM acts on it one cycle later, so the count reads k on the
   // (k+3)th sample and the report appears on sample n+4.
   task automatic measure(input string tag, input int lead, input int n, input int slip_at);
      if (lead > 0) ref_clk = 1'b1;
      else if (lead < 0) dco_clk = 1'b1;
      else begin
         ref_clk = 1'b1;
         dco_clk = 1'b1;
      end
      for (int i = 1; i <= n + 6; i++) begin
         int ev;
         bit et;
         bit es;
         step();
         ev = 0;
         et = 1'b0;
         if (i >= 4 && i <= n + 3) ev = lead * (i - 3);
         else if (i == n + 4) begin
            ev = lead * n;
            et = 1'b1;
         end
         es = (slip_at > 0) && (i == slip_at + 4);
         chk_all($sformatf("%s[%0d]", tag, i), ev, et, es);
         if (slip_at > 0 && i == 1) begin
            if (lead > 0) ref_clk = 1'b0; else dco_clk = 1'b0;
         end
         if (slip_at > 0 && i == slip_at) begin
            if (lead > 0) ref_clk = 1'b1; else dco_clk = 1'b1;
         end
         if (lead != 0 && i == n) begin
            if (lead > 0) dco_clk = 1'b1; else ref_clk = 1'b1;
         end
      end
      ref_clk = 1'b0;
      dco_clk = 1'b0;
      repeat (4) step();
   endtask

   initial begin
      int lead;
      int n;

      rst_n   = 1'b0;
      enable  = 1'b1;
      ref_clk = 1'b0;
      dco_clk = 1'b0;
      repeat (3) step();
      chk_all("reset", 0, 1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (4) step();
      chk_all("post_reset", 0, 1'b0, 1'b0);

      measure("ref_lead10", 1, 10, 0);
      measure("dco_lead7", -1, 7, 0);
      measure("coincident", 0, 0, 0);
      measure("sat_ref20", 1, 20, 0);
      measure("sat_dco20", -1, 20, 0);
      measure("slip", 1, 12, 5);
      measure("slip_dco", -1, 11, 3);

      // Reset at count +4; ref stays high across release and must not count.
      ref_clk = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         chk_all($sformatf("rst_pre[%0d]", i), (i >= 4) ? i - 3 : 0, 1'b0, 1'b0);
      end
      rst_n = 1'b0;
      #1;
      chk_all("rst_mid", 0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         chk_all($sformatf("rst_post[%0d]", i), 0, 1'b0, 1'b0);
      end
      ref_clk = 1'b0;
      repeat (4) step();

      // Disable at count +4, then a dco edge while disabled is ignored.
      ref_clk = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         chk_all($sformatf("dis_pre[%0d]", i), (i >= 4) ? i - 3 : 0, 1'b0, 1'b0);
      end
      enable = 1'b0;
      step();
      chk_all("dis_clear", 0, 1'b0, 1'b0);
      ref_clk = 1'b0;
      dco_clk = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         chk_all($sformatf("dis_idle[%0d]", i), 0, 1'b0, 1'b0);
      end
      enable  = 1'b1;
      dco_clk = 1'b0;
      repeat (4) step();

      // Randomized measurements.
      for (int k = 0; k < 10; k++) begin
         lead = int'($urandom_range(0, 2)) - 1;
         n    = (lead == 0) ? 0 : int'($urandom_range(1, 25));
         measure($sformatf("rand%0d_l%0d_n%0d", k, lead, n), lead, n, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
